// File: rtl/gba_bus_fabric.sv
// gba_bus_fabric
// ---------------------------------------------------------------------------
// Bus fabric between the GBA cartridge-bus front end and N byte-wide
// peripherals. It decodes each request against a per-slave base/mask window,
// with the lowest index winning on overlap. It then issues a one-cycle strobe
// to the hit slave and waits for that slave's ready. The result is reported
// as a registered miso/done pair. Unmapped accesses complete with
// DEFAULT_DATA and an err pulse. Unmapped accesses, timeouts and dropped
// requests are all counted in a saturating err_cnt.
//
// Optional feature macro: GBA_BUS_FABRIC_TIMEOUT_EN
//   defined   : an access whose slave does not raise ready within TIMEOUT
//               cycles completes with DEFAULT_DATA and an err pulse.
//   undefined : the fabric waits indefinitely for ready.
//
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   addr       request address from the GBA front end
//   mosi       write data
//   write      one-cycle write request pulse (wins over a simultaneous read)
//   read       one-cycle read request pulse
//   miso       registered read data back to the GBA side
//   done       one-cycle completion pulse
//   busy       high while a transaction is outstanding
//   err        one-cycle pulse on unmapped access or timeout
//   err_cnt    saturating count of errors and dropped (overrun) requests
//   s_addr     latched address, shared by all slaves
//   s_mosi     latched write data, shared by all slaves
//   s_write    one-hot write strobe
//   s_read     one-hot read strobe
//   s_miso     flattened slave read data, slice i = slave i
//   s_ready    per-slave completion
// ---------------------------------------------------------------------------
module gba_bus_fabric #(
  parameter int unsigned                  N_SLAVES     = 2,
  parameter int unsigned                  ADDR_W       = 16,
  parameter int unsigned                  DATA_W       = 8,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_BASE   = {16'h0000, 16'h0000},
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_MASK   = {16'h0000, 16'hFFFE},
  parameter int unsigned                  TIMEOUT      = 16,
  parameter logic [DATA_W-1:0]            DEFAULT_DATA = 8'hFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           mosi,
  input  logic                        write,
  input  logic                        read,
  output logic [DATA_W-1:0]           miso,
  output logic                        done,
  output logic                        busy,
  output logic                        err,
  output logic [7:0]                  err_cnt,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_mosi,
  output logic [N_SLAVES-1:0]         s_write,
  output logic [N_SLAVES-1:0]         s_read,
  input  logic [N_SLAVES*DATA_W-1:0]  s_miso,
  input  logic [N_SLAVES-1:0]         s_ready
);

  localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  // Reject unusable configurations at elaboration time.
  if (N_SLAVES < 1 || N_SLAVES > 8 || TIMEOUT < 1) begin : g_param_check
    $error("gba_bus_fabric: N_SLAVES must be 1..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_miso;
  logic                r_done;
  logic                r_err;
  logic [7:0]          r_err_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_mosi;
  logic [N_SLAVES-1:0] r_s_write;
  logic [N_SLAVES-1:0] r_s_read;
  logic [SEL_W-1:0]    r_sel;
  logic                r_is_wr;

`ifdef GBA_BUS_FABRIC_TIMEOUT_EN
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0]   r_tcnt;
`endif

  logic                w_hit;
  logic [SEL_W-1:0]    w_sel;
  logic [N_SLAVES-1:0] w_onehot;
  logic                w_req;
  logic                w_idle;
  logic                w_sel_ready;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_timeout;
  logic                w_err_ev;
  logic                w_ovr_ev;
  logic [8:0]          w_cnt_sum;
  logic [7:0]          w_cnt_next;

  // Address decode: scan upward and keep the first hit so the lowest index
  // wins when windows overlap.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!w_hit &&
          ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
        w_hit = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
  end

  assign w_onehot    = N_SLAVES'(1) << w_sel;
  assign w_req       = read | write;
  assign w_idle      = (r_state == IDLE);
  assign w_sel_ready = s_ready[r_sel];
  assign w_sel_data  = s_miso[r_sel*DATA_W +: DATA_W];

`ifdef GBA_BUS_FABRIC_TIMEOUT_EN
  // Ready on the last allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == ACCESS) && !w_sel_ready &&
                     (r_tcnt == TCNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Error and overrun can coincide (e.g. an unmapped write with a read also
  // asserted, or a timeout while a request is dropped). Both are added in the
  // same cycle before saturating.
  assign w_err_ev   = (w_idle && w_req && !w_hit) || w_timeout;
  assign w_ovr_ev   = w_req && (!w_idle || (read && write));
  assign w_cnt_sum  = {1'b0, r_err_cnt} + 9'(w_err_ev) + 9'(w_ovr_ev);
  assign w_cnt_next = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_miso    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_addr    <= '0;
      r_mosi    <= '0;
      r_s_write <= '0;
      r_s_read  <= '0;
      r_sel     <= '0;
      r_is_wr   <= 1'b0;
`ifdef GBA_BUS_FABRIC_TIMEOUT_EN
      r_tcnt    <= '0;
`endif
    end else begin
      r_s_write <= '0;
      r_s_read  <= '0;
      r_err     <= w_err_ev;
      r_err_cnt <= w_cnt_next;

      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_req) begin
            r_addr  <= addr;
            r_mosi  <= mosi;
            r_is_wr <= write;
            r_sel   <= w_sel;
            if (w_hit) begin
              r_state <= ACCESS;
              if (write) r_s_write <= w_onehot;
              else       r_s_read  <= w_onehot;
`ifdef GBA_BUS_FABRIC_TIMEOUT_EN
              r_tcnt  <= '0;
`endif
            end else begin
              r_state <= RESP;
              if (!write) r_miso <= DEFAULT_DATA;
            end
          end
        end

        ACCESS: begin
          if (w_sel_ready) begin
            if (!r_is_wr) r_miso <= w_sel_data;
            r_done  <= 1'b1;
            r_state <= RESP;
          end else if (w_timeout) begin
            if (!r_is_wr) r_miso <= DEFAULT_DATA;
            r_done  <= 1'b1;
            r_state <= RESP;
          end
`ifdef GBA_BUS_FABRIC_TIMEOUT_EN
          else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end

        RESP: begin
          // An unmapped access enters RESP straight from IDLE with done low.
          // It spends one extra cycle here so that done lands in the same
          // cycle as on the fastest mapped access.
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign miso    = r_miso;
  assign done    = r_done;
  assign busy    = (r_state != IDLE);
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign s_addr  = r_addr;
  assign s_mosi  = r_mosi;
  assign s_write = r_s_write;
  assign s_read  = r_s_read;

endmodule

// File: tb/tb_gba_bus_fabric.sv
// tb_gba_bus_fabric
// Directed bench for gba_bus_fabric. A transaction-timeline model of the
// default-parameter instance is checked on every cycle. A second instance
// with a fully-masked address map exercises the unmapped path.
module tb_gba_bus_fabric;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  mosi;
  logic        write, read;
  logic [7:0]  miso;
  logic        done, busy, err;
  logic [7:0]  err_cnt;
  logic [15:0] s_addr;
  logic [7:0]  s_mosi;
  logic [1:0]  s_write, s_read;
  logic [15:0] s_miso;
  logic [1:0]  s_ready;

  logic [15:0] u_addr;
  logic [7:0]  u_mosi;
  logic        u_write, u_read;
  logic [7:0]  u_miso;
  logic        u_done, u_busy, u_err;
  logic [7:0]  u_err_cnt;
  logic [15:0] u_s_addr;
  logic [7:0]  u_s_mosi;
  logic [1:0]  u_s_write, u_s_read;
  logic [15:0] u_s_miso;
  logic [1:0]  u_s_ready;

  always #5 clk = ~clk;

  gba_bus_fabric #(
    .N_SLAVES(2), .ADDR_W(16), .DATA_W(8),
    .SLAVE_BASE({16'h0000, 16'h0000}),
    .SLAVE_MASK({16'h0000, 16'hFFFE}),
    .TIMEOUT(16), .DEFAULT_DATA(8'hFF)
  ) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .mosi(mosi), .write(write), .read(read),
    .miso(miso), .done(done), .busy(busy), .err(err), .err_cnt(err_cnt),
    .s_addr(s_addr), .s_mosi(s_mosi), .s_write(s_write), .s_read(s_read),
    .s_miso(s_miso), .s_ready(s_ready)
  );

  gba_bus_fabric #(
    .N_SLAVES(2), .ADDR_W(16), .DATA_W(8),
    .SLAVE_BASE({16'h0001, 16'h0000}),
    .SLAVE_MASK({16'hFFFF, 16'hFFFF}),
    .TIMEOUT(16), .DEFAULT_DATA(8'hFF)
  ) u_um (
    .clk(clk), .rst(rst), .addr(u_addr), .mosi(u_mosi), .write(u_write), .read(u_read),
    .miso(u_miso), .done(u_done), .busy(u_busy), .err(u_err), .err_cnt(u_err_cnt),
    .s_addr(u_s_addr), .s_mosi(u_s_mosi), .s_write(u_s_write), .s_read(u_s_read),
    .s_miso(u_s_miso), .s_ready(u_s_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-timeline model ----------------
  // Each accepted request is tracked by the edge it was accepted on and the
  // edge after which done is shown.
  int          md_edge    = 0;
  bit          md_busy    = 1'b0;
  bit          md_wr      = 1'b0;
  int          md_acc     = 0;
  int          md_done_at = -1;
  int          md_sel     = 0;
  logic [7:0]  md_miso    = '0;
  logic [7:0]  md_cnt     = '0;
  logic [15:0] md_addr    = '0;
  logic [7:0]  md_mosi    = '0;

  logic [7:0]  e_miso, e_cnt, e_mosi;
  logic [15:0] e_addr;
  logic        e_done, e_busy, e_err;
  logic [1:0]  e_sr, e_sw;

  function automatic int decode(input logic [15:0] a);
    if ((a & 16'hFFFE) == 16'h0000) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin : model
    int inc;
    logic [1:0] sr, sw;
    bit nd, ne;
    md_edge = md_edge + 1;
    inc = 0; sr = '0; sw = '0; nd = 1'b0; ne = 1'b0;
    if (rst) begin
      md_busy = 1'b0; md_done_at = -1; md_miso = '0; md_cnt = '0;
      md_addr = '0;   md_mosi = '0;
    end else if (md_busy) begin
      if (read || write) inc = inc + 1;
      if (md_done_at >= 0 && md_edge == md_done_at + 1) begin
        md_busy = 1'b0;
      end else if (md_done_at < 0) begin
        if (s_ready[md_sel]) begin
          md_done_at = md_edge;
          if (!md_wr) md_miso = s_miso[md_sel*8 +: 8];
        end
`ifdef GBA_BUS_FABRIC_TIMEOUT_EN
        else if (md_edge == md_acc + 16) begin
          md_done_at = md_edge;
          ne = 1'b1; inc = inc + 1;
          if (!md_wr) md_miso = 8'hFF;
        end
`endif
      end
      nd = (md_done_at == md_edge);
    end else if (read || write) begin
      if (read && write) inc = inc + 1;
      md_wr = write; md_acc = md_edge; md_addr = addr; md_mosi = mosi;
      md_busy = 1'b1; md_done_at = -1;
      md_sel = decode(addr);
      if (write) sw = 2'b01 << md_sel;
      else       sr = 2'b01 << md_sel;
    end
    md_cnt = (int'(md_cnt) + inc > 255) ? 8'hFF : 8'(int'(md_cnt) + inc);
    e_miso <= md_miso; e_cnt <= md_cnt; e_addr <= md_addr; e_mosi <= md_mosi;
    e_done <= nd; e_busy <= md_busy; e_err <= ne; e_sr <= sr; e_sw <= sw;
  end

  always @(negedge clk) begin
    if (md_edge > 0) begin
      chk("cyc_miso",    miso,    e_miso);
      chk("cyc_done",    done,    e_done);
      chk("cyc_busy",    busy,    e_busy);
      chk("cyc_err",     err,     e_err);
      chk("cyc_err_cnt", err_cnt, e_cnt);
      chk("cyc_s_addr",  s_addr,  e_addr);
      chk("cyc_s_mosi",  s_mosi,  e_mosi);
      chk("cyc_s_read",  s_read,  e_sr);
      chk("cyc_s_write", s_write, e_sw);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; addr = '0; mosi = '0; write = 1'b0; read = 1'b0;
    s_miso = '0; s_ready = '0;
    u_addr = '0; u_mosi = '0; u_write = 1'b0; u_read = 1'b0;
    u_s_miso = 16'h1122; u_s_ready = 2'b11;

    // Reset held for two cycles.
    tick; tick;
    chk("rst_miso", miso, 8'h00);       chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);        chk("rst_err", err, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h00); chk("rst_s_read", s_read, 2'b00);
    chk("rst_s_write", s_write, 2'b00); chk("rst_s_addr", s_addr, 16'h0000);
    chk("rst_s_mosi", s_mosi, 8'h00);   chk("rst_u_busy", u_busy, 1'b0);
    rst = 1'b0;
    tick;

    // Unmapped read on the fully-masked instance.
    u_addr = 16'h0040; u_read = 1'b1;
    tick;
    u_read = 1'b0;
    chk("um_err", u_err, 1'b1);           chk("um_miso", u_miso, 8'hFF);
    chk("um_s_read", u_s_read, 2'b00);    chk("um_s_write", u_s_write, 2'b00);
    chk("um_err_cnt", u_err_cnt, 8'h01);  chk("um_done_c1", u_done, 1'b0);
    tick;
    chk("um_done_c2", u_done, 1'b1);      chk("um_err_c2", u_err, 1'b0);
    tick;
    chk("um_idle", u_busy, 1'b0);

    // Zero-wait reads to both slaves.
    s_ready = 2'b11; s_miso = {8'h5A, 8'hC3};
    addr = 16'h0001; read = 1'b1;
    tick;
    read = 1'b0;
    chk("zw0_s_read", s_read, 2'b01);
    tick;
    chk("zw0_miso", miso, 8'hC3); chk("zw0_done", done, 1'b1);
    tick;
    addr = 16'h1234; read = 1'b1;
    tick;
    read = 1'b0;
    chk("zw1_s_read", s_read, 2'b10);
    tick;
    chk("zw1_miso", miso, 8'h5A); chk("zw1_done", done, 1'b1);
    tick;

    // Write with wait states; ready on the non-selected slave is ignored.
    s_ready = 2'b00; addr = 16'h0100; mosi = 8'h77; write = 1'b1;
    tick;
    write = 1'b0; mosi = 8'h00;
    chk("wr_s_write", s_write, 2'b10); chk("wr_s_mosi_c1", s_mosi, 8'h77);
    s_ready = 2'b01;
    for (int c = 2; c <= 4; c++) begin
      tick;
      chk("wr_strobe_off", s_write, 2'b00);
      chk("wr_wait_done", done, 1'b0);
      chk("wr_s_mosi_held", s_mosi, 8'h77);
    end
    tick;
    s_ready = 2'b10;
    tick;
    chk("wr_done", done, 1'b1); chk("wr_miso_held", miso, 8'h5A);
    s_ready = 2'b00;
    tick;

    // Second read while busy is dropped and counted.
    s_miso = {8'h5A, 8'h3C}; addr = 16'h0001; read = 1'b1;
    tick;
    tick;
    read = 1'b0;
    chk("ovr_err_cnt", err_cnt, 8'h01); chk("ovr_no_err", err, 1'b0);
    s_ready = 2'b01;
    tick;
    chk("ovr_done", done, 1'b1); chk("ovr_miso", miso, 8'h3C);
    s_ready = 2'b00;
    tick;

    // Simultaneous read and write: the write executes.
    s_ready = 2'b11; addr = 16'h0000; mosi = 8'h99; read = 1'b1; write = 1'b1;
    tick;
    read = 1'b0; write = 1'b0;
    chk("rw_s_write", s_write, 2'b01); chk("rw_s_read", s_read, 2'b00);
    chk("rw_err_cnt", err_cnt, 8'h02);
    tick;
    chk("rw_done", done, 1'b1); chk("rw_miso", miso, 8'h3C);
    tick;

    // Reset mid-transaction aborts without done.
    s_ready = 2'b00; addr = 16'h1234; read = 1'b1;
    tick;
    read = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("abort_busy", busy, 1'b0); chk("abort_done", done, 1'b0);
    chk("abort_err_cnt", err_cnt, 8'h00);
    rst = 1'b0;
    tick;

    // Hung slave with a request held high: err_cnt saturates.
    addr = 16'h1234; read = 1'b1;
    tick;
    for (int c = 0; c < 300; c++) tick;
    read = 1'b0;
    chk("sat_err_cnt", err_cnt, 8'hFF);
`ifndef GBA_BUS_FABRIC_TIMEOUT_EN
    chk("hang_busy", busy, 1'b1);
`endif
    s_ready = 2'b10;
    cyc = 0;
    while (busy && cyc < 50) begin tick; cyc++; end
    chk("release_idle", busy, 1'b0);
    s_ready = 2'b00;
    tick;

`ifdef GBA_BUS_FABRIC_TIMEOUT_EN
    // Timeout: done, err and DEFAULT_DATA at strobe + 16 cycles.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    addr = 16'h1234; read = 1'b1;
    tick;
    read = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin tick; cyc++; end
    chk("to_cycle", cyc, 17); chk("to_err", err, 1'b1);
    chk("to_miso", miso, 8'hFF); chk("to_err_cnt", err_cnt, 8'h01);
    tick; tick;
`endif

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gba_bus_fabric.md
# gba_bus_fabric

Parametrised GBA-side bus fabric between the `GBA` cartridge-bus front end and N byte-wide peripherals (SPI, RAM, future blocks). It replaces the fixed two-way address decode and registered read mux with three things: per-slave base/mask decode, a per-slave ready handshake for multi-cycle peripherals, and a default response for unmapped or hung accesses. It also keeps a saturating error count for debug.

## Interface
Parameters:
- `N_SLAVES`, 2, number of downstream slaves (1..8).
- `ADDR_W`, 16, address width.
- `DATA_W`, 8, data width.
- `SLAVE_BASE`, {16'h0000, 16'h0000}, flattened `N_SLAVES*ADDR_W`; slice i is slave i's base.
- `SLAVE_MASK`, {16'h0000, 16'hFFFE}, flattened; slave i hits when `(addr & mask_i) == base_i`. Default is slave 0 = SPI at 0x0000–0x0001, slave 1 = RAM catch-all.
- `TIMEOUT`, 16, maximum wait cycles for `s_ready` (only with the macro).
- `DEFAULT_DATA`, 8'hFF, read data for unmapped or timed-out accesses.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  ADDR_W  request address from `GBA`.
- `mosi`  in  DATA_W  write data.
- `write`  in  1  one-cycle write request pulse.
- `read`  in  1  one-cycle read request pulse.
- `miso`  out  DATA_W  registered read data to `GBA`.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a transaction is outstanding.
- `err`  out  1  one-cycle pulse on unmapped access or timeout.
- `err_cnt`  out  8  saturating error/overrun count.
- `s_addr`  out  ADDR_W  latched address, common to all slaves.
- `s_mosi`  out  DATA_W  latched write data, common.
- `s_write`  out  N_SLAVES  one-hot write strobe.
- `s_read`  out  N_SLAVES  one-hot read strobe.
- `s_miso`  in  N_SLAVES*DATA_W  flattened slave read data; slice i belongs to slave i.
- `s_ready`  in  N_SLAVES  slave i completes its access.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE → ACCESS:** entered on `read` or `write`.
  - Latch `addr`, `mosi` and the direction.
  - Decode the hit index; the lowest index wins on overlapping windows.
  - Register a one-hot `s_read`/`s_write` pulse (1 cycle) to the hit slave.
- **IDLE → RESP (unmapped):** entered on a request that hits no slave.
  - No strobe is issued.
  - `err` pulses and `err_cnt` increments.
  - `miso <= DEFAULT_DATA` on a read.
- **ACCESS:** waits for `s_ready[sel]`.
  - On ready with a read: `miso <= s_miso[sel]`.
  - On ready with a write: `miso` holds its previous value.
  - Next state is RESP.
  - `s_ready` of non-selected slaves is ignored.
- **RESP:** `done` pulses for 1 cycle, then IDLE.
- `read` and `write` high in the same cycle: the write wins, and the read is counted as an overrun in `err_cnt` (no `err` pulse).
- A request while `busy` is dropped and counted as an overrun; state is unaffected.
- `s_addr`/`s_mosi` are stable from the strobe cycle until `done`.
- `err_cnt` saturates at 8'hFF; it clears only on reset.
- `busy` = state != IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `miso` 0.
  - `done`, `busy`, `err` 0.
  - `err_cnt` 0.
  - `s_write`, `s_read` 0.
  - `s_addr`, `s_mosi` 0.
- `rst` mid-transaction aborts immediately; no `done` is issued.
- Request sampled at edge 0; strobe high in cycle 1.
- `s_ready` is sampled from cycle 1. A zero-wait slave with ready tied high gives `miso` valid and `done` high in cycle 2 (minimum latency 2).
- Each wait cycle adds 1 to the latency.
- Unmapped access: `err` and `miso` update in cycle 1, `done` in cycle 2.
- Back-to-back: the next request is accepted in the cycle after `done`. Minimum request spacing is 3 cycles.

## Configuration
- `GBA_BUS_FABRIC_TIMEOUT_EN` defined:
  - ACCESS has a counter.
  - If `s_ready[sel]` has not been seen after `TIMEOUT` cycles in ACCESS, the transaction completes as RESP: `miso <= DEFAULT_DATA` on a read, `err` pulses, `err_cnt` increments.
- Undefined: no counter; ACCESS waits indefinitely for `s_ready`.

## Test plan
- **Reset:** hold `rst` 2 cycles → all outputs 0, `busy`=0.
- **Zero-wait read:** default params, `s_ready`=2'b11, `s_miso`={8'h5A, 8'hC3}; `read` at addr 0x0001 → `s_read`=2'b01 in cycle 1, `miso`=8'hC3 with `done` in cycle 2. Repeat at addr 0x1234 → `s_read`=2'b10, `miso`=8'h5A.
- **Write with wait:** `write` at 0x0100 with `mosi`=8'h77, `s_ready[1]` raised 4 cycles after the strobe → `s_write`=2'b10 for 1 cycle, `s_mosi`=8'h77 held, `done` 1 cycle after ready, `miso` unchanged.
- **Unmapped:** `SLAVE_MASK` = all 0xFFFF, bases 0/1; read at 0x0040 → no strobe, `err` pulse, `miso`=8'hFF, `err_cnt`=1.
- **Overrun:** a second `read` while `busy` → ignored, `err_cnt` +1, first transaction completes normally. Simultaneous `read`+`write` → the write executes, `err_cnt` +1.
- **Timeout (macro on, `TIMEOUT`=16):** read to slave 1 with `s_ready`=0 → `done`, `err`, `miso`=8'hFF at strobe+16 cycles. With the macro off, `busy` stays high for 100 cycles.
